pong_game_ctrl: RTL
===================

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter BALLS, default 3, number of balls per game (1..3).
REQ-002 Parameter TIMER_TICKS, default 120, pause length in refresh ticks (2 s at 60 Hz).
REQ-003 clk  in  1  system clock.
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 refr_tick  in  1  one-clk pulse per frame refresh.
REQ-006 btn_any  in  1  level, OR of all player buttons.
REQ-007 miss_l  in  1  level, ball lost past left paddle; right player scores.
REQ-008 miss_r  in  1  level, ball lost past right paddle; left player scores.
REQ-009 graph_still  out  1  freezes ball and paddles at centre.
REQ-010 text_sel  out  2  overlay select: 00 none, 01 start, 10 ball-lost, 11 game-over.
REQ-011 score_l, score_r  out  8 each  two-digit BCD scores.
REQ-012 balls_left  out  2  balls remaining.

Function
REQ-013 States SHALL be NEWGAME, PLAY, NEWBALL and OVER, held in one state register.
REQ-014 btn_rise SHALL be btn_any AND NOT its 1-cycle registered copy.
REQ-015 NEWGAME: graph_still=1, text_sel=01, scores 0, balls_left=BALLS; btn_rise -> PLAY on the next edge.
REQ-016 PLAY: graph_still=0, text_sel=00; miss_l or miss_r -> scorer's score +1, balls_left -1, timer loaded TIMER_TICKS, all in the same edge.
REQ-017 Leaving PLAY on a miss: balls_left was 1 -> OVER, else -> NEWBALL.
REQ-018 miss_l and miss_r asserted together: only miss_l SHALL be counted, one ball only.
REQ-019 Misses SHALL be ignored in every state other than PLAY; the miss_* level still asserted after leaving PLAY SHALL NOT be counted again.
REQ-020 NEWBALL: graph_still=1, text_sel=10; timer -1 per refr_tick; transition to PLAY only on btn_rise with timer==0; btn_rise at timer>0 is discarded.
REQ-021 OVER: graph_still=1, text_sel=11; timer -1 per refr_tick; timer==0 -> NEWGAME with no button needed.
REQ-022 Timer width SHALL be ceil(log2(TIMER_TICKS+1)); timer SHALL saturate at 0 and never wrap.
REQ-023 Score increment SHALL be decimal: low digit 9 -> 0 with carry; 99 -> 00 wrap.
REQ-024 Scores SHALL hold in OVER, remaining visible until NEWGAME clears them.
REQ-025 Outputs SHALL be a decode of registered state/counters only, with no combinational path from any input.

Reset
REQ-026 On reset: state NEWGAME, scores 00, balls_left=BALLS, timer 0, button register 0.
REQ-027 Therefore outputs after reset: graph_still=1, text_sel=01.
REQ-028 Reset asserted mid-game SHALL abandon the game immediately with no pending score update.

Structure
REQ-029 Package pong_pkg SHALL hold the state encoding, text_sel codes and BALLS/TIMER_TICKS defaults.
REQ-030 One sub-module, bcd2_counter, SHALL provide the two-digit BCD counter with clear and increment; instantiate one per player.

Verification
REQ-031 Reset, then btn_any pulse -> PLAY, graph_still=0, scores 00, balls_left=3.
REQ-032 In PLAY, miss_r held 5 cycles -> score_l=01 once, balls_left=2, NEWBALL, text_sel=10.
REQ-033 In NEWBALL, btn pulse after 50 ticks -> stays NEWBALL; btn pulse after 120 ticks -> PLAY.
REQ-034 miss_l and miss_r in the same cycle -> score_r+1 only, score_l unchanged, balls_left-1.
REQ-035 Third miss -> OVER, text_sel=11; 120 refr_ticks later -> NEWGAME, scores 00, balls_left=3.
REQ-036 Preload score_r=09, then miss_l -> score_r=10; from 99, miss_l -> 00.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the pong game controller: state encoding, overlay codes,
// default game parameters and the two-digit BCD increment.
package pong_pkg;

   typedef enum logic [1:0] {
      ST_NEWGAME = 2'd0,
      ST_PLAY    = 2'd1,
      ST_NEWBALL = 2'd2,
      ST_OVER    = 2'd3
   } pong_state_t;

   localparam logic [1:0] TXT_NONE  = 2'b00;
   localparam logic [1:0] TXT_START = 2'b01;
   localparam logic [1:0] TXT_LOST  = 2'b10;
   localparam logic [1:0] TXT_OVER  = 2'b11;

   localparam int BALLS_DEF       = 3;
   localparam int TIMER_TICKS_DEF = 120;

   // Decimal increment of a two-digit BCD value; 99 wraps to 00.
   function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
      logic [3:0] lo;
      logic [3:0] hi;
      lo = v[3:0];
      hi = v[7:4];
      if (lo == 4'd9) begin
         lo = 4'd0;
         hi = (hi == 4'd9) ? 4'd0 : hi + 4'd1;
      end else begin
         lo = lo + 4'd1;
      end
      return {hi, lo};
   endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD score counter with synchronous clear (priority) and increment.
module bcd2_counter
   import pong_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       inc,
   output logic [7:0] bcd
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         bcd <= 8'h00;
      else if (clr)
         bcd <= 8'h00;
      else if (inc)
         bcd <= bcd2_inc(bcd);
   end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencing: start screen, play, ball-lost pause and game-over pause,
// with per-player BCD scores and a ball budget.
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int BALLS       = BALLS_DEF,
   parameter int TIMER_TICKS = TIMER_TICKS_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       refr_tick,
   input  logic       btn_any,
   input  logic       miss_l,
   input  logic       miss_r,
   output logic       graph_still,
   output logic [1:0] text_sel,
   output logic [7:0] score_l,
   output logic [7:0] score_r,
   output logic [1:0] balls_left
);

   localparam int TW = $clog2(TIMER_TICKS + 1);

   pong_state_t state, state_next;
   logic [TW-1:0] timer, timer_next;
   logic [1:0]    balls, balls_next;
   logic          btn_reg;
   logic          btn_rise;
   logic          inc_l, inc_r, clr_scores;

   assign btn_rise = btn_any & ~btn_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_NEWGAME;
         timer   <= '0;
         balls   <= 2'(BALLS);
         btn_reg <= 1'b0;
      end else begin
         state   <= state_next;
         timer   <= timer_next;
         balls   <= balls_next;
         btn_reg <= btn_any;
      end
   end

   always_comb begin
      state_next = state;
      timer_next = timer;
      balls_next = balls;
      inc_l      = 1'b0;
      inc_r      = 1'b0;
      clr_scores = 1'b0;
      case (state)
         ST_NEWGAME: begin
            clr_scores = 1'b1;
            balls_next = 2'(BALLS);
            if (btn_rise)
               state_next = ST_PLAY;
         end
         ST_PLAY: begin
            // A simultaneous double miss is charged to the left side only.
            if (miss_l || miss_r) begin
               inc_r      = miss_l;
               inc_l      = ~miss_l;
               balls_next = balls - 2'd1;
               timer_next = TW'(TIMER_TICKS);
               state_next = (balls == 2'd1) ? ST_OVER : ST_NEWBALL;
            end
         end
         ST_NEWBALL: begin
            if (refr_tick && timer != '0)
               timer_next = timer - 1'b1;
            if (btn_rise && timer == '0)
               state_next = ST_PLAY;
         end
         default: begin
            if (refr_tick && timer != '0)
               timer_next = timer - 1'b1;
            // Clear on the way out so NEWGAME never shows the old scores.
            if (timer == '0) begin
               state_next = ST_NEWGAME;
               clr_scores = 1'b1;
               balls_next = 2'(BALLS);
            end
         end
      endcase
   end

   bcd2_counter u_score_l (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_scores),
      .inc   (inc_l),
      .bcd   (score_l)
   );

   bcd2_counter u_score_r (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_scores),
      .inc   (inc_r),
      .bcd   (score_r)
   );

   always_comb begin
      graph_still = (state != ST_PLAY);
      case (state)
         ST_NEWGAME: text_sel = TXT_START;
         ST_PLAY:    text_sel = TXT_NONE;
         ST_NEWBALL: text_sel = TXT_LOST;
         default:    text_sel = TXT_OVER;
      endcase
   end

   assign balls_left = balls;

endmodule
